// File: rtl/ddr_iod_dly_pkg.sv
// ---------------------------------------------------------------------------
// ddr_iod_dly_pkg
// Shared types for the DDR IOD delay-line controller:
//   op_e        - command opcode encodings presented on the command port
//   state_e     - sequencing FSM states
//   rsp_flags_t - response record (strobe + out-of-range flag)
// ---------------------------------------------------------------------------
package ddr_iod_dly_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_QUERY = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_MOVE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOAD   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    typedef struct packed {
        logic valid;
        logic oor;
    } rsp_flags_t;

    // True for the opcodes that walk the delay line tap by tap.
    function automatic logic is_step_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/ddr_iod_dly_settle_timer.sv
// ---------------------------------------------------------------------------
// ddr_iod_dly_settle_timer
// Loadable down-counter. i_load (re)starts it; o_done is high for exactly
// one cycle, SETTLE_CYCLES cycles after the load cycle (i.e. during the last
// settle cycle).
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   i_load  - start a new settle interval
//   o_done  - last settle cycle indicator
// ---------------------------------------------------------------------------
module ddr_iod_dly_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int                CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LOAD_V = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  ONE_V  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO_V = CNT_W'(0);

    logic [CNT_W-1:0] r_cnt;

    // Settle down-counter; parks at zero once the interval has elapsed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= ZERO_V;
        end else if (i_load) begin
            r_cnt <= LOAD_V;
        end else if (r_cnt != ZERO_V) begin
            r_cnt <= r_cnt - ONE_V;
        end
    end

    assign o_done = (r_cnt == ONE_V);

endmodule

// File: rtl/ddr_iod_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_iod_delay_line_ctrl
// Sequences MOVE/DIRECTION/LOAD of up to NUM_LANES IOD delay lines from a
// single command port, keeps a shadow tap count per lane, spaces MOVE pulses
// by SETTLE_CYCLES and stops on IOD out-of-range or shadow saturation.
// All outputs are registered; their next values are decoded from the next
// FSM state so pins line up with the state they belong to.
// Ports:
//   i_fab_clk / i_arst_n           - clock, async active-low reset
//   i_cmd_valid / o_cmd_ready      - command handshake
//   i_cmd_op / i_cmd_lane / i_cmd_steps - command fields
//   o_rsp_valid / o_rsp_tap / o_rsp_oor - one-cycle response
//   o_delay_line_move/direction/load    - per-lane IOD controls
//   i_delay_line_out_of_range           - per-lane IOD range flag
// ---------------------------------------------------------------------------
module ddr_iod_delay_line_ctrl
    import ddr_iod_dly_pkg::*;
#(
    parameter int NUM_LANES     = 8,
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 255,
    parameter int INIT_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_fab_clk,
    input  logic                 i_arst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd_op,
    input  logic [3:0]           i_cmd_lane,
    input  logic [TAP_W-1:0]     i_cmd_steps,
    output logic                 o_rsp_valid,
    output logic [TAP_W-1:0]     o_rsp_tap,
    output logic                 o_rsp_oor,
    output logic [NUM_LANES-1:0] o_delay_line_move,
    output logic [NUM_LANES-1:0] o_delay_line_direction,
    output logic [NUM_LANES-1:0] o_delay_line_load,
    input  logic [NUM_LANES-1:0] i_delay_line_out_of_range
);

    localparam int               IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [4:0]       LANES_V   = 5'(NUM_LANES);
    localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] INIT_V    = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] ONE_V     = TAP_W'(1);
    localparam logic [TAP_W-1:0] ZERO_V    = TAP_W'(0);

    state_e               r_state, w_state_nxt;
    op_e                  r_op, w_op_nxt, w_cmd_op;
    logic [IDX_W-1:0]     r_lane, w_lane_nxt, w_cmd_idx, w_lane_sel;
    logic [TAP_W-1:0]     r_remain, w_remain_nxt;
    logic [TAP_W-1:0]     r_shadow [NUM_LANES];
    logic [TAP_W-1:0]     w_shadow_rd, w_step_tap, w_sh_wdata;
    logic                 w_sh_we, w_bad_lane, w_settle_done, w_timer_load;
    logic                 r_cmd_ready, w_ready_nxt;
    logic [NUM_LANES-1:0] r_move, r_dir, r_load, w_move_nxt, w_dir_nxt, w_load_nxt, w_lane_bit;
    rsp_flags_t           r_rsp, w_rsp_nxt;
    logic [TAP_W-1:0]     r_rsp_tap, w_rsp_tap_nxt;

    // Next step would push the shadow past either end of the legal range.
    function automatic logic f_saturated(input op_e op, input logic [TAP_W-1:0] tap);
        return ((op == OP_INC) && (tap == MAX_TAP_V)) || ((op == OP_DEC) && (tap == ZERO_V));
    endfunction

    assign w_cmd_op     = op_e'(i_cmd_op);
    assign w_cmd_idx    = i_cmd_lane[IDX_W-1:0];
    assign w_bad_lane   = ({1'b0, i_cmd_lane} >= LANES_V);
    // In IDLE the shadow is read for the lane on the command port (QUERY).
    assign w_lane_sel   = (r_state == ST_IDLE) ? w_cmd_idx : r_lane;
    assign w_shadow_rd  = r_shadow[w_lane_sel];
    assign w_step_tap   = (r_op == OP_INC) ? (w_shadow_rd + ONE_V) : (w_shadow_rd - ONE_V);
    assign w_timer_load = (r_state == ST_MOVE);

    ddr_iod_dly_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk   (i_fab_clk),
        .i_rst_n (i_arst_n),
        .i_load  (w_timer_load),
        .o_done  (w_settle_done)
    );

    // Next-state, shadow update and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_lane_nxt    = r_lane;
        w_remain_nxt  = r_remain;
        w_sh_we       = 1'b0;
        w_sh_wdata    = w_step_tap;
        w_rsp_nxt     = '{valid: 1'b0, oor: 1'b0};
        w_rsp_tap_nxt = ZERO_V;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_op_nxt     = w_cmd_op;
                    w_lane_nxt   = w_cmd_idx;
                    w_remain_nxt = i_cmd_steps;
                    if (w_bad_lane) begin
                        w_state_nxt = ST_RESP;
                        w_rsp_nxt   = '{valid: 1'b1, oor: 1'b1};
                    end else if (w_cmd_op == OP_LOAD) begin
                        w_state_nxt = ST_LOAD;
                    end else if (is_step_op(w_cmd_op) && (i_cmd_steps != ZERO_V)) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt   = ST_RESP;
                        w_rsp_nxt     = '{valid: 1'b1, oor: 1'b0};
                        w_rsp_tap_nxt = w_shadow_rd;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (f_saturated(r_op, w_shadow_rd)) begin
                    w_state_nxt   = ST_RESP;
                    w_rsp_nxt     = '{valid: 1'b1, oor: 1'b1};
                    w_rsp_tap_nxt = w_shadow_rd;
                end else begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!w_settle_done) begin
                    w_state_nxt = ST_SETTLE;
                end else if (i_delay_line_out_of_range[r_lane]) begin
                    // IOD refused the move: shadow keeps its old value.
                    w_state_nxt   = ST_RESP;
                    w_rsp_nxt     = '{valid: 1'b1, oor: 1'b1};
                    w_rsp_tap_nxt = w_shadow_rd;
                end else begin
                    w_sh_we      = 1'b1;
                    w_remain_nxt = r_remain - ONE_V;
                    if (r_remain == ONE_V) begin
                        w_state_nxt   = ST_RESP;
                        w_rsp_nxt     = '{valid: 1'b1, oor: 1'b0};
                        w_rsp_tap_nxt = w_step_tap;
                    end else if (f_saturated(r_op, w_step_tap)) begin
                        // Saturation is judged on the value just committed.
                        w_state_nxt   = ST_RESP;
                        w_rsp_nxt     = '{valid: 1'b1, oor: 1'b1};
                        w_rsp_tap_nxt = w_step_tap;
                    end else begin
                        w_state_nxt = ST_MOVE;
                    end
                end
            end
            ST_LOAD: begin
                w_sh_we       = 1'b1;
                w_sh_wdata    = INIT_V;
                w_state_nxt   = ST_RESP;
                w_rsp_nxt     = '{valid: 1'b1, oor: 1'b0};
                w_rsp_tap_nxt = INIT_V;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_lane_bit  = NUM_LANES'(1'b1) << w_lane_nxt;
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_move_nxt  = (w_state_nxt == ST_MOVE) ? w_lane_bit : {NUM_LANES{1'b0}};
        w_load_nxt  = (w_state_nxt == ST_LOAD) ? w_lane_bit : {NUM_LANES{1'b0}};
        // DIRECTION holds from SETUP through the last SETTLE and drops in RESP.
        w_dir_nxt   = (((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_MOVE) ||
                        (w_state_nxt == ST_SETTLE)) && (w_op_nxt == OP_INC)) ?
                      w_lane_bit : {NUM_LANES{1'b0}};
    end

    // FSM state and latched command context.
    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_QUERY;
            r_lane   <= {IDX_W{1'b0}};
            r_remain <= ZERO_V;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_lane   <= w_lane_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Per-lane shadow tap counts.
    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_shadow[i] <= INIT_V;
            end
        end else if (w_sh_we) begin
            r_shadow[r_lane] <= w_sh_wdata;
        end
    end

    // Registered pin and response outputs.
    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_cmd_ready <= 1'b1;
            r_move      <= {NUM_LANES{1'b0}};
            r_dir       <= {NUM_LANES{1'b0}};
            r_load      <= {NUM_LANES{1'b0}};
            r_rsp       <= '{valid: 1'b0, oor: 1'b0};
            r_rsp_tap   <= ZERO_V;
        end else begin
            r_cmd_ready <= w_ready_nxt;
            r_move      <= w_move_nxt;
            r_dir       <= w_dir_nxt;
            r_load      <= w_load_nxt;
            r_rsp       <= w_rsp_nxt;
            r_rsp_tap   <= w_rsp_tap_nxt;
        end
    end

    assign o_cmd_ready            = r_cmd_ready;
    assign o_delay_line_move      = r_move;
    assign o_delay_line_direction = r_dir;
    assign o_delay_line_load      = r_load;
    assign o_rsp_valid            = r_rsp.valid;
    assign o_rsp_oor              = r_rsp.oor;
    assign o_rsp_tap              = r_rsp_tap;

endmodule

// File: tb/tb_ddr_iod_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_iod_delay_line_ctrl
// Directed bench. For every command a behavioural model expands the command
// into its expected per-cycle pin/response timeline (plain loops over taps
// and settle intervals); a single compare process checks the DUT against it
// every cycle. Literal expectations pin the key timing and tap values.
// ---------------------------------------------------------------------------
module tb_ddr_iod_delay_line_ctrl;

    localparam int NL = 8, TW = 8, MAXT = 255, INIT = 1, SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_lane;
    logic [TW-1:0] cmd_steps;
    logic          rsp_valid, rsp_oor;
    logic [TW-1:0] rsp_tap_o;
    logic [NL-1:0] mv_o, dir_o, ld_o, oor_i;

    always #5 clk = ~clk;

    ddr_iod_delay_line_ctrl #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT), .INIT_TAP(INIT), .SETTLE_CYCLES(SC)
    ) dut (
        .i_fab_clk(clk), .i_arst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_lane(cmd_lane), .i_cmd_steps(cmd_steps),
        .o_rsp_valid(rsp_valid), .o_rsp_tap(rsp_tap_o), .o_rsp_oor(rsp_oor),
        .o_delay_line_move(mv_o), .o_delay_line_direction(dir_o),
        .o_delay_line_load(ld_o), .i_delay_line_out_of_range(oor_i)
    );

    typedef struct {
        int       idx;
        logic [7:0] mv, dr, ld;
        logic       rv;
        logic [7:0] tap;
        logic       oor;
        logic       rdy;
    } ent_t;

    ent_t q[$];
    int   sh[NL];
    int   checks = 0, errors = 0;
    bit   chk_en = 1'b0;
    int   rsp_cyc, rsp_tap, rsp_o;
    int   mv_cyc[$], ld_cyc[$];
    int   plan_len, plan_tap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] mv, input logic [7:0] dr, input logic [7:0] ld,
                        input logic rv, input logic [7:0] tap, input logic oor);
        ent_t e;
        e.idx = q.size() + 1;
        e.mv = mv; e.dr = dr; e.ld = ld; e.rv = rv; e.tap = tap; e.oor = oor; e.rdy = 1'b0;
        q.push_back(e);
    endtask

    // Model: expand one command into the cycles 1..N that follow acceptance.
    task automatic plan(input logic [1:0] op, input int lane, input int steps, input int oor_at);
        logic [7:0] lb, d;
        bit oor, inc;
        if (lane >= NL) begin
            push(8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
            return;
        end
        lb  = 8'h01 << lane;
        inc = (op == 2'b01);
        if (op == 2'b11 || ((op == 2'b01 || op == 2'b10) && steps == 0)) begin
            push(8'h00, 8'h00, 8'h00, 1'b1, 8'(sh[lane]), 1'b0);
        end else if (op == 2'b00) begin
            push(8'h00, 8'h00, lb, 1'b0, 8'h00, 1'b0);
            sh[lane] = INIT;
            push(8'h00, 8'h00, 8'h00, 1'b1, 8'(INIT), 1'b0);
        end else begin
            d   = inc ? lb : 8'h00;
            oor = 1'b0;
            push(8'h00, d, 8'h00, 1'b0, 8'h00, 1'b0);
            for (int k = 1; k <= steps; k++) begin
                if ((inc && sh[lane] == MAXT) || (!inc && sh[lane] == 0)) begin
                    oor = 1'b1;
                    break;
                end
                push(lb, d, 8'h00, 1'b0, 8'h00, 1'b0);
                repeat (SC) push(8'h00, d, 8'h00, 1'b0, 8'h00, 1'b0);
                if (k == oor_at) begin
                    oor = 1'b1;
                    break;
                end
                sh[lane] += inc ? 1 : -1;
            end
            push(8'h00, 8'h00, 8'h00, 1'b1, 8'(sh[lane]), oor);
        end
    endtask

    // Compare process: DUT against model timeline every cycle (idle when empty).
    always @(negedge clk) begin
        ent_t e;
        if (chk_en) begin
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e.idx = -1; e.mv = 8'h00; e.dr = 8'h00; e.ld = 8'h00;
                e.rv = 1'b0; e.tap = 8'h00; e.oor = 1'b0; e.rdy = 1'b1;
            end
            chk("move",      mv_o,      e.mv);
            chk("direction", dir_o,     e.dr);
            chk("load",      ld_o,      e.ld);
            chk("rsp_valid", rsp_valid, e.rv);
            chk("rsp_tap",   rsp_tap_o, e.tap);
            chk("rsp_oor",   rsp_oor,   e.oor);
            chk("cmd_ready", cmd_ready, e.rdy);
            if (rsp_valid) begin
                rsp_cyc = e.idx; rsp_tap = int'(rsp_tap_o); rsp_o = int'(rsp_oor);
            end
            if (mv_o != 8'h00) mv_cyc.push_back(e.idx);
            if (ld_o != 8'h00) ld_cyc.push_back(e.idx);
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] lane, input logic [7:0] steps,
                          input int oor_at);
        int rc;
        bit done;
        mv_cyc.delete(); ld_cyc.delete(); rsp_cyc = -1; rsp_tap = -1; rsp_o = -1;
        rc   = (oor_at > 0) ? (2 + (oor_at - 1) * (1 + SC) + 1) : -1;
        done = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_lane = lane; cmd_steps = steps;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        plan(op, int'(lane), int'(steps), oor_at);
        plan_len = q.size();
        plan_tap = int'(q[q.size() - 1].tap);
        for (int c = 1; c <= 3000; c++) begin
            if (c == rc) oor_i[lane] = 1'b1;
            @(posedge clk); #1;
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("cmd_timeout", 32'(done), 32'd1);
        oor_i = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_lane = 4'd0;
        cmd_steps = 8'd0; oor_i = 8'h00;
        for (int l = 0; l < NL; l++) sh[l] = INIT;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_rsp",   rsp_valid, 1'b0);
        chk("rst_pins",  {mv_o, dir_o, ld_o}, 24'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // QUERY lane 3
        do_cmd(2'b11, 4'd3, 8'd0, 0);
        chk("q3_cyc", rsp_cyc, 1); chk("q3_tap", rsp_tap, 1); chk("q3_oor", rsp_o, 0);
        chk("q3_moves", mv_cyc.size(), 0);

        // INC lane 2 by 3
        do_cmd(2'b01, 4'd2, 8'd3, 0);
        chk("inc_plan_len", plan_len, 17); chk("inc_plan_tap", plan_tap, 4);
        chk("inc_npulse", mv_cyc.size(), 3);
        chk("inc_p0", mv_cyc[0], 2); chk("inc_p1", mv_cyc[1], 7); chk("inc_p2", mv_cyc[2], 12);
        chk("inc_cyc", rsp_cyc, 17); chk("inc_tap", rsp_tap, 4); chk("inc_oor", rsp_o, 0);

        // DEC lane 0 from 1 by 5: saturates at 0
        do_cmd(2'b10, 4'd0, 8'd5, 0);
        chk("dec_npulse", mv_cyc.size(), 1);
        chk("dec_cyc", rsp_cyc, 7); chk("dec_tap", rsp_tap, 0); chk("dec_oor", rsp_o, 1);

        // INC lane 5 by 10, IOD out-of-range after 2nd pulse
        do_cmd(2'b01, 4'd5, 8'd10, 2);
        chk("oor_npulse", mv_cyc.size(), 2);
        chk("oor_cyc", rsp_cyc, 12); chk("oor_tap", rsp_tap, 2); chk("oor_oor", rsp_o, 1);

        // Raise lane 1 to 9, then LOAD
        do_cmd(2'b01, 4'd1, 8'd8, 0);
        chk("raise_cyc", rsp_cyc, 42); chk("raise_tap", rsp_tap, 9);
        do_cmd(2'b00, 4'd1, 8'd0, 0);
        chk("ld_n", ld_cyc.size(), 1); chk("ld_c", ld_cyc[0], 1);
        chk("ld_cyc", rsp_cyc, 2); chk("ld_tap", rsp_tap, 1); chk("ld_oor", rsp_o, 0);

        // Bad lane
        do_cmd(2'b01, 4'd12, 8'd3, 0);
        chk("bad_cyc", rsp_cyc, 1); chk("bad_tap", rsp_tap, 0); chk("bad_oor", rsp_o, 1);
        chk("bad_moves", mv_cyc.size(), 0);

        // INC with zero steps behaves like QUERY
        do_cmd(2'b01, 4'd2, 8'd0, 0);
        chk("z_cyc", rsp_cyc, 1); chk("z_tap", rsp_tap, 4); chk("z_moves", mv_cyc.size(), 0);

        // INC lane 7 to the top: saturates at MAX_TAP
        do_cmd(2'b01, 4'd7, 8'd255, 0);
        chk("max_npulse", mv_cyc.size(), 254);
        chk("max_cyc", rsp_cyc, 1272); chk("max_tap", rsp_tap, 255); chk("max_oor", rsp_o, 1);

        // Reset mid-INC on lane 4
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_lane = 4'd4; cmd_steps = 8'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        plan(2'b01, 4, 5, 0);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_dir", dir_o, 8'h10);
        chk_en = 1'b0;
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_move", mv_o, 8'h00); chk("arst_dir", dir_o, 8'h00);
        chk("arst_load", ld_o, 8'h00); chk("arst_rsp", rsp_valid, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_norsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int l = 0; l < NL; l++) sh[l] = INIT;
        chk("arst_ready", cmd_ready, 1'b1);
        chk_en = 1'b1;
        for (int l = 0; l < NL; l++) begin
            do_cmd(2'b11, 4'(l), 8'd0, 0);
            chk("arst_q_tap", rsp_tap, 1);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_iod_delay_line_ctrl.md
Name: ddr_iod_delay_line_ctrl

Overview:
Sequences the dynamic delay-line controls (MOVE/DIRECTION/LOAD) of up to NUM_LANES DDR3 PHY IOD instances from one command interface used by the training/calibration logic. Keeps a shadow tap count per lane, spaces MOVE pulses by a settle interval, and stops early on IOD out-of-range or shadow saturation. Sits in the fabric clock domain between the training FSM and the IOD block array.

Parameters:
NUM_LANES, 8, number of IOD lanes controlled (1..16)
TAP_W, 8, width of tap counts and step counts
MAX_TAP, 255, highest legal shadow tap value
INIT_TAP, 1, shadow tap value after reset and after LOAD (matches the IOD static delay value)
SETTLE_CYCLES, 4, idle cycles after each MOVE pulse before OUT_OF_RANGE is sampled (>=1)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
ARST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  command accepted when VALID&READY
CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 QUERY
CMD_LANE  in  4  target lane index
CMD_STEPS  in  TAP_W  tap steps for INC/DEC; ignored otherwise
RSP_VALID  out  1  one-cycle response strobe
RSP_TAP  out  TAP_W  lane shadow tap after the command
RSP_OOR  out  1  command ended on out-of-range, saturation or bad lane
DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse
DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction (1 = increment)
DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD out-of-range flag

Behaviour:
- Reset, asynchronous on ARST_N low, takes effect even mid-command: FSM to IDLE. Outputs: MOVE/LOAD/DIRECTION/RSP_* = 0, CMD_READY = 1. All shadows = INIT_TAP. No response is issued for an aborted command.
- States: IDLE, SETUP, MOVE, SETTLE, LOAD, RESP. CMD_READY = (state==IDLE).
- Acceptance: on VALID&READY, cycle 0, latch op, lane and steps.
- Bad lane (CMD_LANE >= NUM_LANES): RESP at cycle 1 with RSP_TAP=0 and RSP_OOR=1. No pins toggle.
- QUERY, or INC/DEC with STEPS=0: RESP at cycle 1 with the shadow value and OOR=0.
- LOAD: DELAY_LINE_LOAD[lane]=1 for exactly cycle 1, shadow := INIT_TAP. RESP at cycle 2.
- INC/DEC:
  - SETUP (cycle 1): DIRECTION[lane] driven. It is held through the whole command and returns to 0 in RESP.
  - MOVE: one-cycle MOVE[lane] pulse.
  - SETTLE: SETTLE_CYCLES cycles. On the last settle cycle, sample OUT_OF_RANGE[lane].
    - If high: shadow unchanged, go to RESP with OOR=1.
    - Else: shadow ±1, remaining steps -1, then MOVE if remaining>0, else RESP.
  - Saturation check before each MOVE: INC with shadow==MAX_TAP, or DEC with shadow==0, skips the pulse and goes to RESP with OOR=1.
  - Full-run latency: RSP_VALID at cycle 2 + STEPS*(1+SETTLE_CYCLES).
- Only the addressed lane's bits ever toggle. At most one MOVE or LOAD bit is high in any cycle.
- RESP lasts one cycle: RSP_VALID=1, RSP_TAP/RSP_OOR valid that cycle only (0 otherwise). Next cycle is IDLE. A new command cannot be accepted in the RESP cycle.
- Shadow arithmetic is unsigned TAP_W bits and never wraps.

Decomposition:
- Package ddr_iod_dly_pkg holds: op encodings (OP_LOAD/OP_INC/OP_DEC/OP_QUERY), the FSM state enum, and the response record type.
- One sub-module, ddr_iod_dly_settle_timer: loadable down-counter producing a done pulse after SETTLE_CYCLES.
- Shadow register array and FSM stay in the top module.

Test Plan:
- Reset release, then QUERY lane 3 -> RSP_VALID at cycle 1, RSP_TAP=1, RSP_OOR=0, no MOVE/LOAD activity.
- INC lane 2, STEPS=3, SETTLE_CYCLES=4 -> MOVE[2] pulses at cycles 2, 7, 12; DIRECTION[2]=1 cycles 1..16; RSP at cycle 17 with TAP=4, OOR=0.
- DEC lane 0 from shadow 1, STEPS=5 -> one MOVE pulse, shadow 0, then saturation: RSP TAP=0, OOR=1 at cycle 7.
- INC lane 5, STEPS=10, with OUT_OF_RANGE[5] forced high after the 2nd pulse -> exactly 2 MOVE pulses, RSP TAP=2 (from 1), OOR=1.
- LOAD lane 1 after shadow raised to 9 -> LOAD[1] high only at cycle 1; RSP cycle 2 with TAP=1. Also: CMD_LANE=12 with NUM_LANES=8 -> RSP cycle 1, TAP=0, OOR=1, no pin activity.
- ARST_N pulsed low mid-INC -> MOVE/DIRECTION drop to 0 immediately, no RSP_VALID, CMD_READY=1 after release, all shadows read back 1 via QUERY.
